div16_seq: RTL and testbench
============================

DIV16_SEQ -- requirements
Module: div16_seq

Interface
REQ-001 Parameter WIDTH, default 16, sets the divisor, quotient and remainder width; the dividend is 2*WIDTH bits.
REQ-002 Port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 Port in_valid, input, 1 bit, the dividend/divisor pair is offered.
REQ-005 Port in_ready, output, 1 bit, the block can accept an operand pair.
REQ-006 Port dividend, input, 2*WIDTH bits, unsigned dividend (a 32-bit product word at default).
REQ-007 Port divisor, input, WIDTH bits, unsigned divisor.
REQ-008 Port out_valid, output, 1 bit, the result fields are valid.
REQ-009 Port out_ready, input, 1 bit, the consumer accepts the result.
REQ-010 Port quotient, output, WIDTH bits, unsigned quotient.
REQ-011 Port remainder, output, WIDTH bits, unsigned remainder.
REQ-012 Port div_by_zero, output, 1 bit, the divisor was zero.
REQ-013 Port overflow, output, 1 bit, the quotient does not fit in WIDTH bits.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in CALC and DONE, in_ready SHALL be 0.
REQ-016 An operand pair is accepted when in_valid and in_ready are both 1; on that edge the dividend and divisor SHALL be registered.
REQ-017 On accept with divisor==0, the FSM SHALL go straight to DONE with quotient=all-ones, remainder=dividend[WIDTH-1:0], div_by_zero=1 and overflow=0.
REQ-018 Otherwise, on accept with dividend[2W-1:W] >= divisor, the FSM SHALL go straight to DONE with quotient=all-ones, remainder=0 and overflow=1.
REQ-019 Otherwise the FSM SHALL enter CALC and perform exactly WIDTH restoring steps, one per cycle, MSB first.
REQ-020 Each restoring step, using a WIDTH+1-bit partial remainder, SHALL:
- shift the next dividend bit into the partial remainder;
- subtract the divisor if the result is non-negative;
- shift the quotient bit (1 if subtracted) into the quotient.
REQ-021 An iteration counter SHALL count WIDTH-1 down to 0; when it is 0 at a CALC edge, the FSM SHALL move to DONE.
REQ-022 out_valid SHALL be 1 exactly while in DONE.
REQ-023 Latency for a normal division SHALL be WIDTH+1 edges from accept to out_valid (17 at default); for the zero and overflow cases it SHALL be 1 edge.
REQ-024 In DONE with out_ready=0, quotient, remainder and the flags SHALL be held unchanged.
REQ-025 In DONE with out_ready=1, the FSM SHALL return to IDLE on that edge; a new operand cannot be accepted on the same edge.
REQ-026 in_valid while the block is busy SHALL be ignored, and the operand inputs SHALL NOT affect the calculation in progress.
REQ-027 The result SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor whenever both flags are 0.

Reset
REQ-028 While rst=1 the block SHALL asynchronously hold:
- state=IDLE and counter=0;
- quotient=0 and remainder=0;
- out_valid, div_by_zero and overflow at 0, and in_ready at 1.
REQ-029 A reset in CALC or DONE SHALL abort the operation with no result ever presented.
REQ-030 The first accept SHALL be possible on the first edge after rst deasserts.

Structure
REQ-031 The shared package div16_pkg SHALL hold:
- the state enum (IDLE/CALC/DONE);
- the default WIDTH constant.
REQ-032 One combinational sub-module, div16_step, SHALL implement a single restoring step:
- inputs: partial remainder, dividend bit, divisor;
- outputs: next partial remainder, quotient bit.
The top SHALL instantiate it once and reuse it every CALC cycle.

Verification
REQ-033 Dividend 1000, divisor 7, out_ready=1 -> out_valid on the 17th edge after accept, quotient=142, remainder=6, both flags 0.
REQ-034 Dividend 0xFFFE0001, divisor 0xFFFF -> quotient=0xFFFF, remainder=0, both flags 0.
REQ-035 Dividend 0x00010000, divisor 1 -> overflow=1, quotient=0xFFFF, remainder=0, out_valid 1 edge after accept; divisor 0 with dividend 0x1234 -> div_by_zero=1, quotient=0xFFFF, remainder=0x1234.
REQ-036 out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge, then a back-to-back operand is accepted.
REQ-037 rst pulsed at CALC cycle 8 -> out_valid=0, in_ready=1 immediately; the next operand (100/9) gives quotient=11, remainder=1.

Source files
------------

// File: rtl/div16_pkg.sv
// Shared definitions for the sequential 2W/W unsigned divider.
package div16_pkg;

  // Default operand width: 32-bit dividend, 16-bit divisor/quotient/remainder.
  localparam int DIV_WIDTH = 16;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div16_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when the shifted partial remainder is not smaller than it.
module div16_step
  import div16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   prem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   prem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // A set top bit of the incoming remainder means the shifted value exceeds
  // any WIDTH-bit divisor, so the subtraction always succeeds; the W+1-bit
  // difference is exact because the true result is below the divisor.
  always_comb begin
    shifted   = {prem[WIDTH-1:0], dbit};
    q_bit     = prem[WIDTH] | (shifted >= {1'b0, divisor});
    prem_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/div16_seq.sv
// Sequential unsigned divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one restoring step per cycle, with valid/ready handshakes on both sides.
// Divide-by-zero and quotient overflow are detected at accept time and
// reported after a single edge.
module div16_seq
  import div16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH:0]   prem_reg;       // partial remainder, seeded with dividend high half
  logic [WIDTH-1:0] lo_reg;         // dividend low half, consumed MSB first
  logic [WIDTH-1:0] divisor_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             dbz_reg;
  logic             ovf_reg;

  logic [WIDTH:0]   prem_next;
  logic             q_bit;

  // The single step datapath is shared by every CALC cycle.
  div16_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .prem     (prem_reg),
    .dbit     (lo_reg[WIDTH-1]),
    .divisor  (divisor_reg),
    .prem_next(prem_next),
    .q_bit    (q_bit)
  );

  // Controller and datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      prem_reg      <= '0;
      lo_reg        <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            divisor_reg  <= divisor;
            lo_reg       <= dividend[WIDTH-1:0];
            prem_reg     <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
            in_ready_reg <= 1'b0;
            dbz_reg      <= 1'b0;
            ovf_reg      <= 1'b0;
            if (divisor == '0) begin
              quotient_reg  <= '1;
              remainder_reg <= dividend[WIDTH-1:0];
              dbz_reg       <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              // Quotient would need more than WIDTH bits.
              quotient_reg  <= '1;
              remainder_reg <= '0;
              ovf_reg       <= 1'b1;
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end else begin
              quotient_reg <= '0;
              cnt_reg      <= CW'(WIDTH - 1);
              state_reg    <= CALC;
            end
          end
        end

        CALC: begin
          prem_reg     <= prem_next;
          lo_reg       <= lo_reg << 1;
          quotient_reg <= {quotient_reg[WIDTH-2:0], q_bit};
          if (cnt_reg == '0) begin
            remainder_reg <= prem_next[WIDTH-1:0];
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;
  assign overflow    = ovf_reg;

endmodule

// File: tb/tb_div16_seq.sv
// Self-checking bench for div16_seq: table of known vectors, randomized
// vectors against a reference model, output stall, and mid-calculation reset.
module tb_div16_seq;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2*W-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_by_zero;
  logic          overflow;

  always #5 clk = ~clk;

  div16_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  typedef struct {
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Reference model built on native arithmetic.
  function automatic exp_t model(input logic [31:0] dvd, input logic [15:0] dvs);
    exp_t e;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (dvs == 16'd0) begin
      e.q = 16'hFFFF; e.r = dvd[15:0]; e.dbz = 1'b1; e.lat = 1;
    end else if (dvd[31:16] >= dvs) begin
      e.q = 16'hFFFF; e.r = 16'd0; e.ovf = 1'b1; e.lat = 1;
    end else begin
      logic [31:0] qq, rr;
      qq = dvd / {16'd0, dvs};
      rr = dvd % {16'd0, dvs};
      e.q = qq[15:0]; e.r = rr[15:0]; e.lat = 17;
    end
    return e;
  endfunction

  // Offer one operand pair, track its expected result through the scoreboard,
  // optionally stall the consumer for 'hold' cycles, then complete the handshake.
  task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs,
                        input exp_t e, input int hold);
    int   n;
    exp_t x;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    dividend  = dvd;
    divisor   = dvs;
    @(posedge clk); #1;
    sb.push_back(e);
    in_valid = 1'b0;
    n = 1;
    // Busy period: random operand noise must be ignored.
    while (!out_valid && n < 40) begin
      chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
      in_valid = 1'($urandom_range(0, 1));
      dividend = $urandom;
      divisor  = 16'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    x = sb.pop_front();
    chk("latency", n, x.lat);
    chk("quotient", {16'd0, quotient}, {16'd0, x.q});
    chk("remainder", {16'd0, remainder}, {16'd0, x.r});
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, x.dbz});
    chk("overflow", {31'd0, overflow}, {31'd0, x.ovf});
    chk("in_ready_done", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_quotient", {16'd0, quotient}, {16'd0, x.q});
      chk("hold_remainder", {16'd0, remainder}, {16'd0, x.r});
      chk("hold_flags", {30'd0, div_by_zero, overflow}, {30'd0, x.dbz, x.ovf});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    $display("txn dvd=0x%08h dvs=0x%04h q=0x%04h r=0x%04h dbz=%0b ovf=%0b lat=%0d hold=%0d",
             dvd, dvs, x.q, x.r, x.dbz, x.ovf, n, hold);
  endtask

  vec_t vecs[12];

  initial begin
    exp_t e;
    logic [31:0] t;
    logic [15:0] dv;
    logic [15:0] hi;

    vecs[0]  = '{32'd1000,      16'd7,      16'd142,    16'd6,      1'b0, 1'b0};
    vecs[1]  = '{32'hFFFE0001,  16'hFFFF,   16'hFFFF,   16'h0000,   1'b0, 1'b0};
    vecs[2]  = '{32'h00010000,  16'd1,      16'hFFFF,   16'h0000,   1'b0, 1'b1};
    vecs[3]  = '{32'h00001234,  16'd0,      16'hFFFF,   16'h1234,   1'b1, 1'b0};
    vecs[4]  = '{32'd100,       16'd9,      16'd11,     16'd1,      1'b0, 1'b0};
    vecs[5]  = '{32'd0,         16'd5,      16'd0,      16'd0,      1'b0, 1'b0};
    vecs[6]  = '{32'hFFFFFFFF,  16'd0,      16'hFFFF,   16'hFFFF,   1'b1, 1'b0};
    vecs[7]  = '{32'h0000FFFF,  16'd1,      16'hFFFF,   16'h0000,   1'b0, 1'b0};
    vecs[8]  = '{32'h12345678,  16'h1234,   16'hFFFF,   16'h0000,   1'b0, 1'b1};
    vecs[9]  = '{32'd12345,     16'd100,    16'd123,    16'd45,     1'b0, 1'b0};
    vecs[10] = '{32'h00FFFFFF,  16'h0100,   16'hFFFF,   16'h00FF,   1'b0, 1'b0};
    vecs[11] = '{32'd7,         16'd1000,   16'd0,      16'd7,      1'b0, 1'b0};

    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    rst       = 1'b0;
    #1 rst = 1'b1;
    #12;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_quotient", {16'd0, quotient}, 32'd0);
    chk("reset_remainder", {16'd0, remainder}, 32'd0);
    chk("reset_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known vectors, each expected result taken from the table.
    for (int i = 0; i < 12; i++) begin
      e.q   = vecs[i].q;
      e.r   = vecs[i].r;
      e.dbz = vecs[i].dbz;
      e.ovf = vecs[i].ovf;
      e.lat = (vecs[i].dbz || vecs[i].ovf) ? 1 : 17;
      run_op(vecs[i].dvd, vecs[i].dvs, e, 0);
    end

    // Consumer stall of 5 cycles, then a back-to-back operand.
    run_op(32'd1000, 16'd7, model(32'd1000, 16'd7), 5);
    run_op(32'hFFFE0001, 16'hFFFF, model(32'hFFFE0001, 16'hFFFF), 0);
    // Stall on a one-edge (overflow) result as well.
    run_op(32'h00010000, 16'd1, model(32'h00010000, 16'd1), 3);

    // Randomized operands checked against the model.
    for (int i = 0; i < 20; i++) begin
      dv = 16'($urandom);
      if (i % 5 == 0) dv = 16'd0;
      t = $urandom;
      if (i % 3 == 0 || dv == 16'd0) hi = t[31:16];
      else hi = 16'(32'(t[31:16]) % {16'd0, dv});
      t = {hi, t[15:0]};
      run_op(t, dv, model(t, dv), i % 3);
    end

    // Reset during CALC: operation abandoned, nothing ever presented.
    while (!in_ready) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    dividend = 32'd1000;
    divisor  = 16'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_quotient", {16'd0, quotient}, 32'd0);
    chk("abort_remainder", {16'd0, remainder}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    run_op(32'd100, 16'd9, '{16'd11, 16'd1, 1'b0, 1'b0, 17}, 0);

    // First accept right on the first edge after reset release.
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(32'd1000, 16'd7, '{16'd142, 16'd6, 1'b0, 1'b0, 17}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
